// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// Accepts one load/store at a time over valid/ready, waits LATENCY cycles,
// performs the access on an internal word-addressed RAM, then holds the
// response until the initiator takes it.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_addr            byte address (must be word aligned and in range)
//   req_wdata, req_be   store data and per-byte enables
//   resp_valid          response present, held until resp_ready
//   resp_ready          initiator consumes the response
//   resp_rdata          load data (0 for stores and faults)
//   resp_err            request faulted (misaligned or out of range)
module dmem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT = 4'(LATENCY);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        live_q;  // low until the first edge after reset release
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        do_access;
    logic        fault;
    logic        mem_wr;
    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic [AW-1:0] acc_idx;

    assign req_ready  = (state_q == StIdle) && live_q;
    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign accept = req_valid && req_ready;

    // With zero latency the access happens on the accepting edge, so the
    // operands come straight from the request instead of the latched copy.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    assign acc_idx = acc_addr[AW+1:2];
    assign fault   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    assign mem_wr  = do_access && acc_we && !fault;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LAT == 4'd0) begin
                        state_d   = StResp;
                        do_access = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = LAT;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    state_d   = StResp;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            live_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (do_access) begin
                err_q   <= fault;
                rdata_q <= (fault || acc_we) ? 32'd0 : mem[acc_idx];
            end else if ((state_q == StResp) && resp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // RAM is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: one instance with LATENCY=2 and one
// with LATENCY=0 share the request bus; sel picks which one is driven/observed.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        sel;  // 1: LATENCY=2 instance, 0: LATENCY=0 instance
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_ready;

    logic        rr2, rv2, er2, rr0, rv0, er0;
    logic [31:0] rd2, rd0;
    logic        rr_m, rv_m, er_m;
    logic [31:0] rd_m;

    assign rr_m = sel ? rr2 : rr0;
    assign rv_m = sel ? rv2 : rv0;
    assign er_m = sel ? er2 : er0;
    assign rd_m = sel ? rd2 : rd0;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid && sel),
        .req_ready  (rr2),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (rv2),
        .resp_ready (resp_ready),
        .resp_rdata (rd2),
        .resp_err   (er2)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid && !sel),
        .req_ready  (rr0),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (rv0),
        .resp_ready (resp_ready),
        .resp_rdata (rd0),
        .resp_err   (er0)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One full transaction with resp_ready=1. Entered and left 1ns after a
    // rising edge. lat = edges after acceptance until resp_valid is seen,
    // -1 if it never appears.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic e,
                        output int lat);
        int n;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        n = 0;
        while (!rr_m && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rv_m && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        rd = rd_m;
        e  = er_m;
        if (!rv_m) lat = -1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        int bad;
        reset      = 1'b0;
        sel        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'd0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (rr2 !== 1'b0 || rr0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_ready: got %b/%b expected 0/0", rr2, rr0);
        end
        checks++;
        if (rv2 !== 1'b0 || rd2 !== 32'd0 || er2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_l2: got v=%b d=%h e=%b expected 0/0/0", rv2, rd2, er2);
        end
        checks++;
        if (rv0 !== 1'b0 || rd0 !== 32'd0 || er0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp_l0: got v=%b d=%h e=%b expected 0/0/0", rv0, rd0, er0);
        end
        #3 reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (rr2 !== 1'b1 || rr0 !== 1'b1) begin
            errors++;
            $display("FAIL release_req_ready: got %b/%b expected 1/1", rr2, rr0);
        end
        bad = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (rv2 !== 1'b0 || rv0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_no_resp: got %0d spurious cycles expected 0", bad);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic        e;
        int          lat;
        sel = 1'b1;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL store_latency: got %0d expected 2", lat);
        end
        checks++;
        if (rd !== 32'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL store_resp: got d=%h e=%b expected 0/0", rd, e);
        end
        checks++;
        if (rr_m !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_consume: got %b expected 1", rr_m);
        end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat != 2) begin
            errors++;
            $display("FAIL load_0x10: got d=%h e=%b lat=%0d expected deadbeef/0/2", rd, e, lat);
        end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd;
        logic        e;
        int          lat;
        sel = 1'b1;
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e, lat);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, e, lat);
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_merge: got %h expected 11bb33dd", rd);
        end
        xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, e, lat);
        checks++;
        if (lat != 2 || e !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL be0_resp: got lat=%0d e=%b d=%h expected 2/0/0", lat, e, rd);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be0_nochange: got %h expected 11bb33dd", rd);
        end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic        e;
        int          lat;
        sel = 1'b1;
        xact(1'b1, 32'(4 * (DEPTH - 1)), 32'h76543210, 4'hF, rd, e, lat);
        xact(1'b0, 32'h22, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'd0) begin
            errors++;
            $display("FAIL misaligned_load: got e=%b d=%h expected 1/0", e, rd);
        end
        xact(1'b1, 32'(4 * DEPTH), 32'h0BADF00D, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1 || lat != 2) begin
            errors++;
            $display("FAIL oor_store: got e=%b lat=%0d expected 1/2", e, lat);
        end
        xact(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'h76543210) begin
            errors++;
            $display("FAIL last_word: got e=%b d=%h expected 0/76543210", e, rd);
        end
        xact(1'b1, 32'h21, 32'h0, 4'hF, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL misaligned_store: got e=%b expected 1", e);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h11BB33DD || e !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_nowrite: got d=%h e=%b expected 11bb33dd/0", rd, e);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] cap;
        int          n;
        int          bad;
        sel        = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h10;
        req_be     = 4'h0;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        n   = 0;
        bad = 0;
        while (!rv_m && n < 40) begin
            if (rr_m !== 1'b0) bad++;
            @(posedge clock); #1;
            n++;
        end
        cap = rd_m;
        checks++;
        if (!rv_m || cap !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bp_first: got v=%b d=%h expected 1/deadbeef", rv_m, cap);
        end
        repeat (5) begin
            @(posedge clock); #1;
            if (rv_m !== 1'b1 || rd_m !== cap || er_m !== 1'b0 || rr_m !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (rr_m !== 1'b1 || rv_m !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", rr_m, rv_m);
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          bad;
        sel = 1'b1;
        xact(1'b1, 32'h30, 32'h01020304, 4'hF, rd, e, lat);
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h55555555;
        req_be    = 4'hF;
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if (rv_m !== 1'b0 || rr_m !== 1'b0) begin
            errors++;
            $display("FAIL in_wait: got v=%b r=%b expected 0/0", rv_m, rr_m);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (rv_m !== 1'b0 || rr_m !== 1'b0 || rd_m !== 32'd0 || er_m !== 1'b0) begin
            errors++;
            $display("FAIL wait_reset_outs: got v=%b r=%b d=%h e=%b expected 0/0/0/0",
                     rv_m, rr_m, rd_m, er_m);
        end
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        bad = 0;
        repeat (8) begin
            @(posedge clock); #1;
            if (rv_m !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL dropped_no_resp: got %0d response cycles expected 0", bad);
        end
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'h01020304 || e !== 1'b0) begin
            errors++;
            $display("FAIL dropped_no_write: got d=%h e=%b expected 01020304/0", rd, e);
        end
    endtask

    task automatic test_latency0();
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          bad;
        sel = 1'b0;
        xact(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd, e, lat);
        checks++;
        if (lat != 0 || e !== 1'b0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL l0_store: got lat=%0d e=%b d=%h expected 0/0/0", lat, e, rd);
        end
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (lat != 0 || rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL l0_load: got lat=%0d d=%h expected 0/cafef00d", lat, rd);
        end
        // Reset lands while a store is being presented: it must never happen.
        req_we    = 1'b1;
        req_addr  = 32'h30;
        req_wdata = 32'h12345678;
        req_be    = 4'hF;
        req_valid = 1'b1;
        #1 reset = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if (rv0 !== 1'b0 || rr0 !== 1'b0) begin
            errors++;
            $display("FAIL l0_reset_outs: got v=%b r=%b expected 0/0", rv0, rr0);
        end
        #3 reset = 1'b1;
        bad = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (rv0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL l0_no_resp: got %0d response cycles expected 0", bad);
        end
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, e, lat);
        checks++;
        if (rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL l0_no_write: got %h expected cafef00d", rd);
        end
        // Reset while a load response is being held.
        req_we     = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if (rv0 !== 1'b1 || rd0 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL l0_held: got v=%b d=%h expected 1/cafef00d", rv0, rd0);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rv0 !== 1'b0 || rd0 !== 32'd0 || er0 !== 1'b0) begin
            errors++;
            $display("FAIL l0_resp_reset: got v=%b d=%h e=%b expected 0/0/0", rv0, rd0, er0);
        end
        #2 reset = 1'b1;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (rr0 !== 1'b1) begin
            errors++;
            $display("FAIL l0_ready_after: got %b expected 1", rr0);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enables();
        test_faults();
        test_back_pressure();
        test_reset_midflight();
        test_latency0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
